// File: rtl/sp_request_queue.sv
// rtl/sp_request_queue.sv - ordered scratchpad request queue with speculative-entry squash/commit
//
// Circular buffer between execute (matrix load/store/GEMM) and the scratchpad.
// Each entry carries a speculation bit; a speculative head is held back, and
// all speculative entries (always the youngest contiguous run) are dropped on
// a squash or committed on a resolve.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   wen/wdata/wspec   push request, 38-bit packed payload, issued-under-branch flag
//   full              queue holds DEPTH entries (registered)
//   spec_resolve      commit all speculative entries
//   spec_squash       drop all speculative entries
//   rvalid/rdata      head entry present and non-speculative / head payload
//   rready            scratchpad accepts the head entry
//   count             current occupancy
//   overflow          sticky: push attempted while full

module sp_request_queue #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wen,
    input  logic [37:0]   wdata,
    input  logic          wspec,
    output logic          full,
    input  logic          spec_resolve,
    input  logic          spec_squash,
    output logic          rvalid,
    output logic [37:0]   rdata,
    input  logic          rready,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);

    logic [37:0]    payload_q [DEPTH];
    logic [DEPTH-1:0] spec_q, spec_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  spec_cnt_q, spec_cnt_d;
    logic           overflow_q, overflow_d;

    logic           push_acc;
    logic           pop;
    logic           push_spec;
    logic [CW-1:0]  squash_amt;

    assign full     = (count_q == CW'(DEPTH));
    assign rvalid   = (count_q != '0) && !spec_q[head_q];
    assign rdata    = payload_q[head_q];
    assign count    = count_q;
    assign overflow = overflow_q;

    // A squash in the same cycle drops the push outright.
    assign push_acc = wen && !full && !spec_squash;
    assign pop      = rvalid && rready;

    // A non-speculative push behind speculative entries must stay behind them,
    // so it inherits speculation unless this cycle's resolve commits them.
    assign push_spec  = wspec || ((spec_cnt_q != '0) && !spec_resolve);
    assign squash_amt = spec_squash ? spec_cnt_q : '0;

    always_comb begin
        spec_d     = spec_q;
        head_d     = head_q + PW'(pop);
        // Truncation to PW bits gives the modulo-DEPTH rewind, including spec_cnt==DEPTH.
        tail_d     = tail_q + PW'(push_acc) - squash_amt[PW-1:0];
        count_d    = count_q + CW'(push_acc) - CW'(pop) - squash_amt;
        overflow_d = overflow_q | (wen && full && !spec_squash);
        spec_cnt_d = spec_cnt_q;

        // After a squash every surviving entry is non-speculative, so clearing
        // all bits is exact for both squash and resolve.
        if (spec_squash || spec_resolve) begin
            spec_d = '0;
        end
        if (push_acc) begin
            spec_d[tail_q] = push_spec;
        end

        if (spec_squash) begin
            spec_cnt_d = '0;
        end else if (spec_resolve) begin
            spec_cnt_d = CW'(push_acc && wspec);
        end else begin
            spec_cnt_d = spec_cnt_q + CW'(push_acc && push_spec);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            spec_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            spec_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            spec_q     <= spec_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            spec_cnt_q <= spec_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload contents are don't-care after reset; occupancy gates their use.
    always_ff @(posedge CLK) begin
        if (push_acc) begin
            payload_q[tail_q] <= wdata;
        end
    end

endmodule

// File: doc/sp_request_queue.md
# sp_request_queue

Ordered request queue between the execute stage's matrix load/store and GEMM units and the scratchpad. Execute pushes one packed request per cycle, and the scratchpad drains the queue through a valid/ready handshake. Every entry carries a speculation bit. The head is released only when its entry is non-speculative, and all speculative entries are dropped together when a branch mispredicts.

## Interface
Parameters:
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- wen  in  1  push request from execute.
- wdata  in  38  packed request: [37:36] type (01 load, 10 store, 11 GEMM, 00 reserved); [35:32] matrix rd/select; [31:0] address or GEMM payload (bits [31:16] zero for GEMM).
- wspec  in  1  the pushed request was issued under an unresolved branch.
- full  out  1  queue holds DEPTH entries.
- spec_resolve  in  1  the branch resolved correctly; commit all speculative entries.
- spec_squash  in  1  the branch mispredicted; drop all speculative entries.
- rvalid  out  1  the head entry is present and non-speculative.
- rdata  out  38  head entry payload.
- rready  in  1  the scratchpad accepts the head entry.
- count  out  CW  current occupancy.
- overflow  out  1  sticky flag: a push was attempted while full.

## Operation
- Storage is a circular buffer: payload array, spec bit array, head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, occupancy register count, speculative-entry counter spec_cnt.
- Speculative entries are always the youngest contiguous run, ending at tail-1.
- A push with wspec=0 while spec_cnt>0 is stored as speculative. This preserves ordering.
- Push accept: wen && !full && !spec_squash. On accept:
  - write wdata to payload[tail];
  - write (wspec || spec_cnt>0) to spec bit[tail];
  - increment tail.
- Push while full: dropped, and overflow is set. overflow clears only on reset.
- Push with type 00: stored and forwarded unchanged. The queue does not decode payloads.
- Pop: rvalid && rready increments head. A speculative head is never popped.
- rvalid = (count!=0) && !spec[head]. rdata = payload[head], driven even when rvalid=0.
- spec_squash: tail -= spec_cnt (mod DEPTH); count -= spec_cnt; spec_cnt = 0. Any push in the same cycle is dropped, without setting overflow.
- spec_resolve (without squash): every spec bit clears and spec_cnt = 0. A push in the same cycle takes its own wspec value and ignores spec_cnt.
- spec_squash and spec_resolve in the same cycle: squash wins and resolve is ignored.
- Pop combined with squash: legal. The popped head is non-speculative, so it is unaffected.
- count update per cycle: count + push_accept − pop − (squash ? spec_cnt : 0).

## Timing
- Reset (async assert; deassert synchronous to CLK):
  - head, tail, count, spec_cnt and all spec bits = 0;
  - full=0, rvalid=0, overflow=0, rdata = payload[0] (contents don't-care).
- All state updates on the rising edge of CLK.
- full, rvalid and count come from registered state only. There is no combinational path from wen or rready.
- Push-to-rvalid latency is 1 cycle for a non-speculative push into an empty queue. There is no fall-through.
- Resolve-to-rvalid latency is 1 cycle when the head was speculative.
- A push and a pop in the same cycle while count==DEPTH: the push is rejected, because full is registered, and the pop proceeds.
- A push and a pop in the same cycle while 0<count<DEPTH: both happen and count is unchanged.
- Sustained throughput is one push and one pop per cycle.
- Reset asserted mid-operation discards all entries immediately. Asynchronously, rvalid drops to 0 and count goes to 0.

## Test plan
- Reset, then push load {01, 4'h3, 32'h0000_1000}, wspec=0, rready=0 → next cycle rvalid=1, rdata=38'h1_3000_01000, count=1. Then rready=1 → following cycle rvalid=0, count=0.
- DEPTH=8: push 9 entries back-to-back with rready=0 → full=1 after the 8th push, the 9th is dropped, overflow=1, count=8. Drain 8 → entries come out in push order with correct wrap of head and tail.
- Push A (wspec=0), then B and C (wspec=1), then D (wspec=0), rready=1 → only A pops. Assert spec_squash → count drops from 3 to 0. The next push E is at the old B slot and pops as E.
- Push B (wspec=1), then assert spec_resolve for 1 cycle → rvalid rises the cycle after resolve and B pops.
- spec_squash and spec_resolve together while 2 speculative entries are queued and wen=1 → both entries dropped, push dropped, overflow unchanged, count=0.
- Steady state at count=4: push and pop every cycle for 20 cycles → count stays 4, output order matches input order, pointers wrap cleanly. Then assert RST mid-stream → rvalid=0 and count=0 asynchronously.
